// File: rtl/fib_matpow_seq.sv
// rtl/fib_matpow_seq.sv - Fibonacci/Lucas engine via 2x2 matrix fast exponentiation
// One square-and-multiply step per cycle; result = F(n) or L(n) mod 2^DATA_W.
module fib_matpow_seq #(
    parameter int DATA_W = 32,
    parameter int N_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_ra, r_rb, r_rd;
    logic [DATA_W-1:0] r_ma, r_mb, r_md;
    logic [N_W-1:0]    r_e;
    logic              r_mode_q;

    // Matrices are symmetric [[a,b],[b,d]], so three elements fully describe each one.
    logic [DATA_W-1:0] w_ra_n, w_rb_n, w_rd_n;
    logic [DATA_W-1:0] w_ma_n, w_mb_n, w_md_n;
    logic [DATA_W-1:0] w_lucas;

    assign w_ra_n  = r_ra * r_ma + r_rb * r_mb;
    assign w_rb_n  = r_ra * r_mb + r_rb * r_md;
    assign w_rd_n  = r_rb * r_mb + r_rd * r_md;
    assign w_ma_n  = r_ma * r_ma + r_mb * r_mb;
    assign w_mb_n  = r_ma * r_mb + r_mb * r_md;
    assign w_md_n  = r_mb * r_mb + r_md * r_md;
    assign w_lucas = r_ra + r_rd;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_md     <= '0;
            r_e      <= '0;
            r_mode_q <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra     <= DATA_W'(1);
                        r_rb     <= '0;
                        r_rd     <= DATA_W'(1);
                        r_ma     <= DATA_W'(1);
                        r_mb     <= DATA_W'(1);
                        r_md     <= '0;
                        r_e      <= n;
                        r_mode_q <= mode;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_e != '0) begin
                        if (r_e[0]) begin
                            r_ra <= w_ra_n;
                            r_rb <= w_rb_n;
                            r_rd <= w_rd_n;
                        end
                        r_ma <= w_ma_n;
                        r_mb <= w_mb_n;
                        r_md <= w_md_n;
                        r_e  <= r_e >> 1;
                    end else begin
                        // R = Q^n = [[F(n+1),F(n)],[F(n),F(n-1)]]; trace gives L(n).
                        r_result <= r_mode_q ? w_lucas : r_rb;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_matpow_seq.sv
// tb/tb_fib_matpow_seq.sv - self-checking bench for fib_matpow_seq
// Reference uses Fibonacci fast-doubling identities, independent of the matrix form.
module tb_fib_matpow_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n = '0;
    logic        mode = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_result = '0;

    fib_matpow_seq #(.DATA_W(32), .N_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n), .mode(mode),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic int bitlen(input logic [31:0] k);
        for (int i = 31; i >= 0; i--) if (k[i]) return i + 1;
        return 0;
    endfunction

    // F(2k) = F(k)(2F(k+1)-F(k)), F(2k+1) = F(k)^2 + F(k+1)^2; L(n) = 2F(n+1) - F(n).
    function automatic logic [31:0] ref_val(input logic [31:0] k, input logic m);
        logic [31:0] f, g, f2, g2;
        f = 32'd0;
        g = 32'd1;
        for (int i = 31; i >= 0; i--) begin
            f2 = f * ((g << 1) - f);
            g2 = f * f + g * g;
            if (k[i]) begin
                f = g2;
                g = f2 + g2;
            end else begin
                f = f2;
                g = g2;
            end
        end
        return m ? ((g << 1) - f) : f;
    endfunction

    // Caller is just after a negedge or in the done cycle; returns #1 after edge 0.
    task automatic issue(input logic [31:0] k, input logic m);
        start = 1'b1;
        n     = k;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int inject_at, input logic [31:0] inject_n,
                             output logic [31:0] res, output int lat);
        lat = 0;
        res = '0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both", busy, done);
            end
            if (done) begin
                res = result;
                prev_result = result;
                break;
            end
            checks++;
            if (busy !== 1'b1 || result !== prev_result) begin
                errors++;
                $display("FAIL run_state busy=%0b result=%0d required busy=1 result=%0d",
                         busy, result, prev_result);
            end
            if (lat > 60) begin
                errors++;
                $display("FAIL timeout lat=%0d required done within 60", lat);
                break;
            end
            if (lat == inject_at) begin
                start = 1'b1;
                n     = inject_n;
                mode  = ~mode;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] res, input int lat,
                            input logic [31:0] exp_res, input int exp_lat);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s_result got=%0d required=%0d", name, res, exp_res);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d required=%0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy=%0b done=%0b result=%0d required 0 0 0", busy, done, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_result = '0;
    endtask

    task automatic test_fib10();
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        issue(32'd10, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("fib10", r, lat, 32'd55, 5);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd55) begin
            errors++;
            $display("FAIL fib10_done_width done=%0b result=%0d required done=0 result=55", done, result);
        end
    endtask

    task automatic test_small();
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        issue(32'd0, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("f0", r, lat, 32'd0, 1);
        @(negedge clk);
        issue(32'd0, 1'b1);
        wait_done(-1, '0, r, lat);
        check_op("l0", r, lat, 32'd2, 1);
        @(negedge clk);
        issue(32'd5, 1'b1);
        wait_done(-1, '0, r, lat);
        check_op("l5", r, lat, 32'd11, 4);
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        issue(32'd47, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("f47", r, lat, 32'hB11924E1, 7);
        @(negedge clk);
        issue(32'd48, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("f48", r, lat, 32'd512559680, 7);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        issue(32'd10, 1'b0);
        wait_done(2, 32'd3, r, lat);
        check_op("ignore_midrun", r, lat, 32'd55, 5);
        issue(32'd20, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("done_cycle_start", r, lat, 32'd6765, 6);
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        issue(32'd1000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset busy=%0b done=%0b result=%0d required 0 0 0", busy, done, result);
        end
        #10;
        rst_n = 1'b1;
        prev_result = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
                errors++;
                $display("FAIL post_reset_idle cycle=%0d busy=%0b done=%0b result=%0d required 0 0 0",
                         i, busy, done, result);
            end
        end
        @(negedge clk);
        issue(32'd1, 1'b0);
        wait_done(-1, '0, r, lat);
        check_op("f1_after_reset", r, lat, 32'd1, 2);
    endtask

    task automatic test_random_sweep();
        logic [31:0] k, r;
        logic        m;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            k = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) k = $urandom_range(0, 3);
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(k, m);
            wait_done(-1, '0, r, lat);
            check_op($sformatf("rand%0d_n%0d_m%0d", i, k, m), r, lat, ref_val(k, m), bitlen(k) + 1);
        end
    endtask

    initial begin
        test_reset();
        test_fib10();
        test_small();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
